// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Purpose  : Writer side of the instruction memory. Receives a byte stream
//            over a valid/ready handshake, framed as a 16-bit big-endian word
//            count followed by 4*N data bytes (each word MSB first), and
//            writes the assembled 32-bit words to consecutive word addresses
//            starting at BASE_ADDR. The core is held stalled while a load is
//            running or after a load has been rejected.
// Ports    :
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active-low
//   start         in   single-cycle request to begin a load
//   byte_in       in   [7:0] stream data byte
//   byte_valid    in   byte_in holds a valid byte
//   byte_ready    out  loader can accept a byte this cycle
//   imem_we       out  instruction memory write strobe
//   imem_addr     out  [31:0] instruction memory byte address
//   imem_wdata    out  [31:0] instruction word to write
//   cpu_hold      out  stall the pipeline (PC load / IF_ID write blocked)
//   busy          out  load in progress
//   done          out  one-cycle pulse on successful completion
//   error         out  illegal word count, sticky until next start
//   words_loaded  out  [15:0] words written in the current/last load
// Revision : 1.0  initial release
// ============================================================================
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic [15:0] r_words;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_xfer;
  logic [15:0] w_len_full;

  assign w_xfer       = byte_valid && byte_ready;
  // Full count as it becomes known while the low length byte is accepted.
  assign w_len_full   = {r_len[15:8], byte_in};
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) begin
          if (w_len_full == 16'd0)                  w_next = S_DONE;
          else if ({1'b0, w_len_full} > c_max_words) w_next = S_ERROR;
          else                                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer && r_idx == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        if (r_words + 16'd1 == r_len) w_next = S_DONE;
        else                          w_next = S_DATA;
      end
      S_DONE: begin
        done   = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      default: begin
        cpu_hold = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

  // Datapath. Address and data are captured with the 4th byte so they stay
  // stable (last written values) whenever imem_we is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= 16'd0;
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
      r_words <= 16'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) r_words <= 16'd0;
        end
        S_LEN_HI: begin
          if (w_xfer) r_len[15:8] <= byte_in;
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= byte_in;
            r_idx      <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], byte_in};
            if (r_idx == 2'd3) begin
              r_wdata <= {r_shift, byte_in};
              r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
            end
          end
        end
        S_WRITE: begin
          r_words <= r_words + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory: the pipeline only fetches from instruction memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS words.
- Writes each word to consecutive word addresses starting at BASE_ADDR.
- Holds the core stalled (cpu_hold) while a program is loading or a load has failed.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction written
MAX_WORDS, 1024, largest accepted word count (instruction memory depth)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  single-cycle request to begin a load
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in holds a valid byte
byte_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write strobe
imem_addr  output  32  instruction memory byte address
imem_wdata  output  32  instruction word to write
cpu_hold  output  1  stall/hold the pipeline (PC load and IF_ID write blocked)
busy  output  1  load in progress
done  output  1  one-cycle pulse: load completed successfully
error  output  1  word count illegal; sticky until next start
words_loaded  output  16  number of words written in the current/last load

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, words_loaded=0, internal count/byte index/shift register cleared. Memory contents untouched.
- Byte transfer occurs only on a cycle with byte_valid && byte_ready. byte_in is ignored otherwise.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes. Each word is sent MSB first (byte 0 -> wdata[31:24]).
- States:
  - IDLE: byte_ready=0, cpu_hold=0. start=1 -> LEN_HI; clear words_loaded, error.
  - LEN_HI: byte_ready=1; accepted byte -> N[15:8]; -> LEN_LO.
  - LEN_LO: byte_ready=1; accepted byte -> N[7:0]. Next state: N==0 -> DONE; N>MAX_WORDS -> ERROR; else DATA with byte index 0.
  - DATA: byte_ready=1. Each accepted byte shifts in and increments the byte index (2 bits). The 4th byte goes to WRITE.
  - WRITE (exactly 1 cycle): byte_ready=0; imem_we=1; imem_addr=BASE_ADDR+4*words_loaded (32-bit wrap); imem_wdata=assembled word; words_loaded increments at the end of the cycle. If words_loaded+1==N -> DONE, else -> DATA.
  - DONE (1 cycle): done=1, byte_ready=0; -> IDLE.
  - ERROR: error=1, byte_ready=0, cpu_hold=1. Stays until start=1, which behaves as start from IDLE.
- busy=1 in LEN_HI, LEN_LO, DATA, WRITE, DONE.
- cpu_hold=1 in every state except IDLE; it deasserts the cycle after the done pulse.
- start while busy: ignored.
- imem_addr/imem_wdata are held stable outside WRITE (last values), qualified only by imem_we.
- Back-to-back: with byte_valid held high, one word costs 5 cycles (4 bytes + 1 write). A byte presented during WRITE waits; it is not lost.
- Reset asserted mid-load: immediate return to IDLE, cpu_hold drops. Words already written remain in memory; no further writes occur.
- Latency: the write of word i occurs the cycle after its 4th byte is accepted.

Test Plan:
- Reset, then start, then stream 00 02 12 34 56 78 9A BC DE F0 with valid always high -> two imem_we pulses: addr 0x0 data 0x12345678, then addr 0x4 data 0x9ABCDEF0. done pulses exactly once. words_loaded=2. cpu_hold is high from the cycle after start through the done cycle.
- Bench gaps: drop byte_valid randomly, and assert valid during the WRITE cycle -> same writes and data as above. Verify no byte is dropped or duplicated, and byte_ready=0 during WRITE.
- Length 00 00 -> no imem_we, done pulses 1 cycle after the LEN_LO byte, words_loaded=0, back to IDLE.
- Length 0x0401 with MAX_WORDS=1024 -> ERROR. error=1 and cpu_hold=1 persist while bytes keep arriving (byte_ready=0). A new start clears error and reloads correctly.
- After 1 word (addr 0x0) of a 3-word load, assert rst=0 for 1 cycle -> all outputs 0 immediately, no further writes. A new start then loads from BASE_ADDR.
- BASE_ADDR=32'h0000_0100: 1-word load of AABBCCDD -> single write, addr 0x100 data 0xAABBCCDD. A start pulse during busy has no effect.
